// File: rtl/mips_ctrl_pkg.sv
// Shared constants and state encoding for the multicycle MIPS sequencer.
package mips_ctrl_pkg;

  // Opcodes (IR[31:26]) and the JR function code (IR[5:0])
  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpLui   = 6'h0F;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;
  localparam logic [5:0] FunctJr = 6'h08;

  // ALU operation codes
  localparam logic [2:0] AluLui   = 3'b000;
  localparam logic [2:0] AluOr    = 3'b001;
  localparam logic [2:0] AluAnd   = 3'b010;
  localparam logic [2:0] AluSub   = 3'b011;
  localparam logic [2:0] AluAdd   = 3'b100;
  localparam logic [2:0] AluFunct = 3'b111;

  // PC source select
  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;
  localparam logic [1:0] PcSrcRs     = 2'b11;

  // Register destination select
  localparam logic [1:0] RegDstRt = 2'b00;
  localparam logic [1:0] RegDstRd = 2'b01;
  localparam logic [1:0] RegDstRa = 2'b10;

  // Register write-data select
  localparam logic [1:0] MemToRegAluOut = 2'b00;
  localparam logic [1:0] MemToRegMdr    = 2'b01;
  localparam logic [1:0] MemToRegPc     = 2'b10;

  // ALU operand B select
  localparam logic [1:0] AluSrcBRt    = 2'b00;
  localparam logic [1:0] AluSrcBFour  = 2'b01;
  localparam logic [1:0] AluSrcBImm   = 2'b10;
  localparam logic [1:0] AluSrcBImmSh = 2'b11;

  typedef enum logic [3:0] {
    StReset, StFetch, StDecode, StExecR, StWbR, StExecI, StWbI, StMemAddr,
    StMemRd, StWbMem, StMemWr, StBranch, StJump, StJal, StJr
  } state_e;

  function automatic logic is_legal_op(input logic [5:0] op);
    case (op)
      OpRtype, OpJ, OpJal, OpBeq, OpBne, OpAddi,
      OpAndi, OpOri, OpLui, OpLw, OpSw: is_legal_op = 1'b1;
      default:                          is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Combinational output decode: current state (+ opcode, mem_ready) to datapath controls.
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_e      state_i,
  input  logic [5:0]  opcode_i,
  input  logic        mem_ready_i,
  output logic        pc_write_o,
  output logic        pc_write_eq_o,
  output logic        pc_write_ne_o,
  output logic [1:0]  pc_source_o,
  output logic        i_or_d_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        ir_write_o,
  output logic [1:0]  reg_dst_o,
  output logic [1:0]  mem_to_reg_o,
  output logic        reg_write_o,
  output logic        alu_src_a_o,
  output logic [1:0]  alu_src_b_o,
  output logic [2:0]  alu_op_o,
  output logic        illegal_o,
  output logic        retired_o
);

  // Per-state control decode; everything not named for a state stays 0
  always_comb begin
    pc_write_o    = 1'b0;
    pc_write_eq_o = 1'b0;
    pc_write_ne_o = 1'b0;
    pc_source_o   = PcSrcAlu;
    i_or_d_o      = 1'b0;
    mem_read_o    = 1'b0;
    mem_write_o   = 1'b0;
    ir_write_o    = 1'b0;
    reg_dst_o     = RegDstRt;
    mem_to_reg_o  = MemToRegAluOut;
    reg_write_o   = 1'b0;
    alu_src_a_o   = 1'b0;
    alu_src_b_o   = AluSrcBRt;
    alu_op_o      = AluLui;
    illegal_o     = 1'b0;
    retired_o     = 1'b0;
    unique case (state_i)
      StFetch: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = AluSrcBFour;
        alu_op_o    = AluAdd;
        // IR and PC+4 commit only once the fetch data is actually there
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
      end
      StDecode: begin
        alu_src_b_o = AluSrcBImmSh;
        alu_op_o    = AluAdd;
        illegal_o   = !is_legal_op(opcode_i);
      end
      StExecR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = AluSrcBRt;
        alu_op_o    = AluFunct;
      end
      StWbR: begin
        reg_dst_o   = RegDstRd;
        reg_write_o = 1'b1;
        retired_o   = 1'b1;
      end
      StExecI: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = AluSrcBImm;
        case (opcode_i)
          OpAndi:  alu_op_o = AluAnd;
          OpOri:   alu_op_o = AluOr;
          OpLui:   alu_op_o = AluLui;
          default: alu_op_o = AluAdd;
        endcase
      end
      StWbI: begin
        reg_write_o = 1'b1;
        retired_o   = 1'b1;
      end
      StMemAddr: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = AluSrcBImm;
        alu_op_o    = AluAdd;
      end
      StMemRd: begin
        i_or_d_o   = 1'b1;
        mem_read_o = 1'b1;
      end
      StWbMem: begin
        mem_to_reg_o = MemToRegMdr;
        reg_write_o  = 1'b1;
        retired_o    = 1'b1;
      end
      StMemWr: begin
        i_or_d_o    = 1'b1;
        mem_write_o = 1'b1;
        retired_o   = mem_ready_i;
      end
      StBranch: begin
        alu_src_a_o   = 1'b1;
        alu_src_b_o   = AluSrcBRt;
        alu_op_o      = AluSub;
        pc_source_o   = PcSrcAluOut;
        pc_write_eq_o = (opcode_i == OpBeq);
        pc_write_ne_o = (opcode_i == OpBne);
        retired_o     = 1'b1;
      end
      StJump: begin
        pc_source_o = PcSrcJump;
        pc_write_o  = 1'b1;
        retired_o   = 1'b1;
      end
      StJal: begin
        pc_source_o  = PcSrcJump;
        pc_write_o   = 1'b1;
        reg_dst_o    = RegDstRa;
        mem_to_reg_o = MemToRegPc;
        reg_write_o  = 1'b1;
        retired_o    = 1'b1;
      end
      StJr: begin
        pc_source_o = PcSrcRs;
        pc_write_o  = 1'b1;
        retired_o   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS sequencer: state register and next-state logic; outputs come from outdec.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [5:0]  opcode_i,
  input  logic [5:0]  funct_i,
  input  logic        zero_i,
  input  logic        mem_ready_i,
  output logic        pc_write_o,
  output logic        pc_write_eq_o,
  output logic        pc_write_ne_o,
  output logic [1:0]  pc_source_o,
  output logic        i_or_d_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        ir_write_o,
  output logic [1:0]  reg_dst_o,
  output logic [1:0]  mem_to_reg_o,
  output logic        reg_write_o,
  output logic        alu_src_a_o,
  output logic [1:0]  alu_src_b_o,
  output logic [2:0]  alu_op_o,
  output logic        illegal_o,
  output logic        retired_o
);

  state_e state_q, state_d;

  // The branch condition is resolved in the datapath, not here
  logic unused_zero;
  assign unused_zero = zero_i;

  // State register; async reset forces RESET so outputs drop immediately
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= StReset;
    else          state_q <= state_d;
  end

  // Next-state sequencing; memory states hold until mem_ready_i
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StReset: state_d = StFetch;
      StFetch: if (mem_ready_i) state_d = StDecode;
      StDecode: begin
        case (opcode_i)
          OpRtype:                      state_d = (funct_i == FunctJr) ? StJr : StExecR;
          OpAddi, OpAndi, OpOri, OpLui: state_d = StExecI;
          OpLw, OpSw:                   state_d = StMemAddr;
          OpBeq, OpBne:                 state_d = StBranch;
          OpJ:                          state_d = StJump;
          OpJal:                        state_d = StJal;
          default:                      state_d = StFetch;
        endcase
      end
      StExecR:   state_d = StWbR;
      StExecI:   state_d = StWbI;
      StMemAddr: state_d = (opcode_i == OpSw) ? StMemWr : StMemRd;
      StMemRd:   if (mem_ready_i) state_d = StWbMem;
      StMemWr:   if (mem_ready_i) state_d = StFetch;
      StWbR, StWbI, StWbMem, StBranch, StJump, StJal, StJr: state_d = StFetch;
      default:   state_d = StReset;
    endcase
  end

  mips_ctrl_outdec u_outdec (
    .state_i       (state_q),
    .opcode_i      (opcode_i),
    .mem_ready_i   (mem_ready_i),
    .pc_write_o    (pc_write_o),
    .pc_write_eq_o (pc_write_eq_o),
    .pc_write_ne_o (pc_write_ne_o),
    .pc_source_o   (pc_source_o),
    .i_or_d_o      (i_or_d_o),
    .mem_read_o    (mem_read_o),
    .mem_write_o   (mem_write_o),
    .ir_write_o    (ir_write_o),
    .reg_dst_o     (reg_dst_o),
    .mem_to_reg_o  (mem_to_reg_o),
    .reg_write_o   (reg_write_o),
    .alu_src_a_o   (alu_src_a_o),
    .alu_src_b_o   (alu_src_b_o),
    .alu_op_o      (alu_op_o),
    .illegal_o     (illegal_o),
    .retired_o     (retired_o)
  );

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: per-cycle check of the full control word.
module tb_mips_multicycle_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic [5:0] opcode_i;
  logic [5:0] funct_i;
  logic       zero_i;
  logic       mem_ready_i;
  logic       pc_write_o, pc_write_eq_o, pc_write_ne_o;
  logic [1:0] pc_source_o;
  logic       i_or_d_o, mem_read_o, mem_write_o, ir_write_o;
  logic [1:0] reg_dst_o, mem_to_reg_o;
  logic       reg_write_o, alu_src_a_o;
  logic [1:0] alu_src_b_o;
  logic [2:0] alu_op_o;
  logic       illegal_o, retired_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  mips_multicycle_ctrl dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .opcode_i      (opcode_i),
    .funct_i       (funct_i),
    .zero_i        (zero_i),
    .mem_ready_i   (mem_ready_i),
    .pc_write_o    (pc_write_o),
    .pc_write_eq_o (pc_write_eq_o),
    .pc_write_ne_o (pc_write_ne_o),
    .pc_source_o   (pc_source_o),
    .i_or_d_o      (i_or_d_o),
    .mem_read_o    (mem_read_o),
    .mem_write_o   (mem_write_o),
    .ir_write_o    (ir_write_o),
    .reg_dst_o     (reg_dst_o),
    .mem_to_reg_o  (mem_to_reg_o),
    .reg_write_o   (reg_write_o),
    .alu_src_a_o   (alu_src_a_o),
    .alu_src_b_o   (alu_src_b_o),
    .alu_op_o      (alu_op_o),
    .illegal_o     (illegal_o),
    .retired_o     (retired_o)
  );

  // Observed control word, field order matches ev()
  logic [21:0] obs;
  assign obs = {pc_write_o, pc_write_eq_o, pc_write_ne_o, pc_source_o, i_or_d_o, mem_read_o,
                mem_write_o, ir_write_o, reg_dst_o, mem_to_reg_o, reg_write_o, alu_src_a_o,
                alu_src_b_o, alu_op_o, illegal_o, retired_o};

  function automatic logic [21:0] ev(
    input logic pcw, input logic eq, input logic ne, input logic [1:0] pcs,
    input logic iord, input logic mr, input logic mw, input logic irw,
    input logic [1:0] rd, input logic [1:0] m2r, input logic rw, input logic asa,
    input logic [1:0] asb, input logic [2:0] aop, input logic ill, input logic ret);
    ev = {pcw, eq, ne, pcs, iord, mr, mw, irw, rd, m2r, rw, asa, asb, aop, ill, ret};
  endfunction

  task automatic check_eq(input string tag, input logic [21:0] got, input logic [21:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %06h expected %06h", tag, got, exp);
    end
  endtask

  // Drive mem_ready, check this cycle's outputs, then advance to the next negedge
  task automatic cyc(input string tag, input logic rdy, input logic [21:0] exp);
    mem_ready_i = rdy;
    #1;
    check_eq(tag, obs, exp);
    @(negedge clk_i);
  endtask

  logic [21:0] e_zero, e_fw, e_fr, e_dec, e_ill, e_exr, e_wbr, e_exori, e_wbi, e_ma;
  logic [21:0] e_mrd, e_wbm, e_mww, e_mwr, e_beq, e_bne, e_j, e_jal, e_jr;

  initial begin
    //            pcw eq ne pcs  iord mr mw irw rd     m2r    rw asa asb    aop     ill ret
    e_zero  = '0;
    e_fw    = ev(0, 0, 0, 2'b00, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 2'b01, 3'b100, 0, 0);
    e_fr    = ev(1, 0, 0, 2'b00, 0, 1, 0, 1, 2'b00, 2'b00, 0, 0, 2'b01, 3'b100, 0, 0);
    e_dec   = ev(0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b11, 3'b100, 0, 0);
    e_ill   = ev(0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b11, 3'b100, 1, 0);
    e_exr   = ev(0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b00, 3'b111, 0, 0);
    e_wbr   = ev(0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b01, 2'b00, 1, 0, 2'b00, 3'b000, 0, 1);
    e_exori = ev(0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b10, 3'b001, 0, 0);
    e_wbi   = ev(0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 2'b00, 3'b000, 0, 1);
    e_ma    = ev(0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b10, 3'b100, 0, 0);
    e_mrd   = ev(0, 0, 0, 2'b00, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 3'b000, 0, 0);
    e_wbm   = ev(0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b01, 1, 0, 2'b00, 3'b000, 0, 1);
    e_mww   = ev(0, 0, 0, 2'b00, 1, 0, 1, 0, 2'b00, 2'b00, 0, 0, 2'b00, 3'b000, 0, 0);
    e_mwr   = ev(0, 0, 0, 2'b00, 1, 0, 1, 0, 2'b00, 2'b00, 0, 0, 2'b00, 3'b000, 0, 1);
    e_beq   = ev(0, 1, 0, 2'b01, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b00, 3'b011, 0, 1);
    e_bne   = ev(0, 0, 1, 2'b01, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b00, 3'b011, 0, 1);
    e_j     = ev(1, 0, 0, 2'b10, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 3'b000, 0, 1);
    e_jal   = ev(1, 0, 0, 2'b10, 0, 0, 0, 0, 2'b10, 2'b10, 1, 0, 2'b00, 3'b000, 0, 1);
    e_jr    = ev(1, 0, 0, 2'b11, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 3'b000, 0, 1);

    rst_n_i = 1'b0; opcode_i = 6'h00; funct_i = 6'h20; zero_i = 1'b0; mem_ready_i = 1'b1;
    @(negedge clk_i);

    // ADD: RESET, FETCH, DECODE, EXEC_R, WB_R
    cyc("rst_held", 1, e_zero);
    rst_n_i = 1'b1;
    cyc("rst_rel", 1, e_zero);
    cyc("add_fetch", 1, e_fr);
    cyc("add_dec", 1, e_dec);
    cyc("add_exec", 1, e_exr);
    cyc("add_wb", 1, e_wbr);

    // LW: 2 fetch waits, 1 read wait -> 8 cycles
    opcode_i = 6'h23;
    cyc("lw_fwait1", 0, e_fw);
    cyc("lw_fwait2", 0, e_fw);
    cyc("lw_fetch", 1, e_fr);
    cyc("lw_dec", 0, e_dec);
    cyc("lw_addr", 0, e_ma);
    cyc("lw_rwait", 0, e_mrd);
    cyc("lw_rd", 1, e_mrd);
    cyc("lw_wb", 0, e_wbm);

    // ORI
    opcode_i = 6'h0D;
    cyc("ori_fetch", 1, e_fr);
    cyc("ori_dec", 1, e_dec);
    cyc("ori_exec", 1, e_exori);
    cyc("ori_wb", 1, e_wbi);

    // SW with one write wait
    opcode_i = 6'h2B;
    cyc("sw_fetch", 1, e_fr);
    cyc("sw_dec", 1, e_dec);
    cyc("sw_addr", 1, e_ma);
    cyc("sw_wwait", 0, e_mww);
    cyc("sw_wr", 1, e_mwr);

    // BEQ then BNE
    opcode_i = 6'h04;
    cyc("beq_fetch", 1, e_fr);
    cyc("beq_dec", 1, e_dec);
    cyc("beq_br", 1, e_beq);
    opcode_i = 6'h05;
    cyc("bne_fetch", 1, e_fr);
    cyc("bne_dec", 1, e_dec);
    cyc("bne_br", 1, e_bne);

    // JAL then JR
    opcode_i = 6'h03;
    cyc("jal_fetch", 1, e_fr);
    cyc("jal_dec", 1, e_dec);
    cyc("jal_exec", 1, e_jal);
    opcode_i = 6'h00; funct_i = 6'h08;
    cyc("jr_fetch", 1, e_fr);
    cyc("jr_dec", 1, e_dec);
    cyc("jr_exec", 1, e_jr);

    // Illegal opcode returns straight to FETCH; follow with J
    opcode_i = 6'h3F;
    cyc("ill_fetch", 1, e_fr);
    cyc("ill_dec", 1, e_ill);
    opcode_i = 6'h02;
    cyc("ill_next_fetch", 1, e_fr);
    cyc("j_dec", 1, e_dec);
    cyc("j_exec", 1, e_j);

    // Async reset in the middle of a stalled SW
    opcode_i = 6'h2B;
    cyc("sw2_fetch", 1, e_fr);
    cyc("sw2_dec", 1, e_dec);
    cyc("sw2_addr", 0, e_ma);
    mem_ready_i = 1'b0;
    #1 check_eq("sw2_wwait", obs, e_mww);
    #2 rst_n_i = 1'b0;
    #1 check_eq("rst_async", obs, e_zero);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    cyc("rst2_reset", 0, e_zero);
    cyc("rst2_fwait", 0, e_fw);
    cyc("rst2_fetch", 1, e_fr);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
